// File: rtl/fetch_queue_pkg.sv
// Shared types for the instruction fetch queue: bus request/response, queue entry, FSM states.
package fetch_queue_pkg;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
    } ibus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } ibus_resp_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        addrError;
    } fq_entry_t;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        KILL_REQ,
        KILL_WAIT
    } fq_state_e;

    function automatic logic isAligned(input logic [31:0] addr);
        return addr[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/fq_ram.sv
// Fetch queue storage: one write port, one asynchronous read port; contents are never reset.
module fq_ram
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     wrEn,
    input  logic [$clog2(DEPTH)-1:0] wrAddr,
    input  fq_entry_t                wrData,
    input  logic [$clog2(DEPTH)-1:0] rdAddr,
    output fq_entry_t                rdData
);

    fq_entry_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wrEn) begin
            mem[wrAddr] <= wrData;
        end
    end

    assign rdData = mem[rdAddr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch unit: one outstanding bus request feeding a small in-order queue,
// with redirect flushing and kill tracking for in-flight requests.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'hbfc0_0000
) (
    input  logic                       clk,
    input  logic                       resetn,
    output ibus_req_t                  ireq,
    input  ibus_resp_t                 iresp,
    input  logic                       redirect_valid,
    input  logic [31:0]                redirect_pc,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_pc,
    output logic [31:0]                out_instr,
    output logic                       out_addr_error,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    fq_state_e   stateReg, stateNext;
    logic [31:0] fetchPcReg;
    logic [31:0] busAddrReg;
    logic [AW-1:0] wrPtrReg, rdPtrReg;
    logic [CW-1:0] countReg;
    logic        haltReg;

    fq_entry_t   headEntry, pushEntry;
    logic        doPop, doPush, busPush, errPush, freeSlot, pcAligned;

    assign pcAligned = isAligned(fetchPcReg);
    assign doPop     = out_valid & out_ready & ~redirect_valid;
    assign freeSlot  = (countReg != FULL) | doPop;
    // A misaligned PC produces one error entry, then fetch parks until redirected.
    assign errPush   = (stateReg == IDLE) & freeSlot & ~pcAligned & ~haltReg & ~redirect_valid;
    assign busPush   = ~redirect_valid & iresp.data_ok &
                       (((stateReg == REQ) & iresp.addr_ok) | (stateReg == WAIT));
    assign doPush    = busPush | errPush;

    always_comb begin
        pushEntry = '0;
        if (errPush) begin
            pushEntry.pc        = fetchPcReg;
            pushEntry.addrError = 1'b1;
        end else begin
            pushEntry.pc    = busAddrReg;
            pushEntry.instr = iresp.data;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stateReg <= IDLE;
        end else begin
            stateReg <= stateNext;
        end
    end

    always_comb begin
        stateNext = stateReg;
        case (stateReg)
            IDLE: begin
                if (!redirect_valid && !haltReg && freeSlot && pcAligned) begin
                    stateNext = REQ;
                end
            end
            REQ: begin
                if (iresp.addr_ok) begin
                    if (iresp.data_ok)       stateNext = IDLE;
                    else if (redirect_valid) stateNext = KILL_WAIT;
                    else                     stateNext = WAIT;
                end else if (redirect_valid) begin
                    stateNext = KILL_REQ;
                end
            end
            WAIT: begin
                if (iresp.data_ok)       stateNext = IDLE;
                else if (redirect_valid) stateNext = KILL_WAIT;
            end
            KILL_REQ: begin
                if (iresp.addr_ok) stateNext = iresp.data_ok ? IDLE : KILL_WAIT;
            end
            KILL_WAIT: begin
                if (iresp.data_ok) stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    // busAddrReg keeps the issued address stable in KILL_REQ while fetchPcReg moves on.
    always_comb begin
        ireq       = '0;
        ireq.valid = (stateReg == REQ) || (stateReg == KILL_REQ);
        ireq.addr  = busAddrReg;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            fetchPcReg <= RESET_PC;
            busAddrReg <= RESET_PC;
            wrPtrReg   <= '0;
            rdPtrReg   <= '0;
            countReg   <= '0;
            haltReg    <= 1'b0;
        end else if (redirect_valid) begin
            fetchPcReg <= redirect_pc;
            wrPtrReg   <= '0;
            rdPtrReg   <= '0;
            countReg   <= '0;
            haltReg    <= 1'b0;
        end else begin
            if (stateReg == IDLE) busAddrReg <= fetchPcReg;
            if (doPush)           wrPtrReg   <= wrPtrReg + 1'b1;
            if (doPop)            rdPtrReg   <= rdPtrReg + 1'b1;
            if (busPush)          fetchPcReg <= fetchPcReg + 32'd4;
            if (errPush)          haltReg    <= 1'b1;
            case ({doPush, doPop})
                2'b10:   countReg <= countReg + 1'b1;
                2'b01:   countReg <= countReg - 1'b1;
                default: countReg <= countReg;
            endcase
        end
    end

    fq_ram #(.DEPTH(DEPTH)) uRam (
        .clk    (clk),
        .wrEn   (doPush),
        .wrAddr (wrPtrReg),
        .wrData (pushEntry),
        .rdAddr (rdPtrReg),
        .rdData (headEntry)
    );

    assign out_valid      = (countReg != '0);
    assign out_pc         = headEntry.pc;
    assign out_instr      = headEntry.instr;
    assign out_addr_error = out_valid & headEntry.addrError;
    assign count          = countReg;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: a scripted bus, and a scoreboard of expected entries checked on every pop.
module tb_fetch_queue;
    import fetch_queue_pkg::*;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        out_ready = 1'b0;
    ibus_req_t   ireq;
    ibus_resp_t  iresp = '0;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        out_addr_error;
    logic [2:0]  count;

    int checks = 0;
    int failures = 0;
    logic [64:0] sbq [$];

    fetch_queue dut (
        .clk            (clk),
        .resetn         (resetn),
        .ireq           (ireq),
        .iresp          (iresp),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
        .out_addr_error (out_addr_error),
        .count          (count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic doReset();
        resetn = 1'b0;
        iresp = '0;
        redirect_valid = 1'b0;
        out_ready = 1'b0;
        sbq.delete();
        tick();
        resetn = 1'b1;
    endtask

    task automatic waitReq(input logic [31:0] expAddr, input string tag);
        int n = 0;
        while (ireq.valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_req_valid"}, ireq.valid, 1);
        chk({tag, "_req_addr"}, ireq.addr, expAddr);
    endtask

    task automatic fetchOne(input logic [31:0] expAddr, input logic [31:0] data,
                            input int addrDelay, input string tag);
        waitReq(expAddr, tag);
        for (int i = 0; i < addrDelay; i++) begin
            tick();
            chk({tag, "_addr_hold"}, ireq.addr, expAddr);
        end
        iresp.addr_ok = 1'b1;
        tick();
        iresp.addr_ok = 1'b0;
        iresp.data_ok = 1'b1;
        iresp.data = data;
        sbq.push_back({expAddr, data, 1'b0});
        tick();
        iresp.data_ok = 1'b0;
    endtask

    // Every accepted head entry must match the oldest expected entry.
    always @(negedge clk) begin
        if (resetn && !redirect_valid && out_valid && out_ready) begin
            if (sbq.size() == 0) begin
                checks++;
                failures++;
                $error("FAIL pop_unexpected observed_pc=%0h expected=no_entry", out_pc);
            end else begin
                chk("pop_entry", {out_pc, out_instr, out_addr_error}, sbq.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic anyReq;

        // Reset state and in-order streaming
        resetn = 1'b0;
        tick();
        chk("rst_ireq_valid", ireq.valid, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_count", count, 0);
        chk("rst_addr_error", out_addr_error, 0);
        resetn = 1'b1;
        out_ready = 1'b1;
        fetchOne(32'hbfc00000, 32'h11110000, 0, "t1a");
        fetchOne(32'hbfc00004, 32'h11110004, 0, "t1b");
        fetchOne(32'hbfc00008, 32'h11110008, 0, "t1c");
        repeat (3) tick();
        chk("t1_drained", sbq.size(), 0);
        chk("t1_count", count, 0);

        // Full queue stalls fetch; one pop frees exactly one request
        doReset();
        for (int i = 0; i < 4; i++) begin
            fetchOne(32'hbfc00000 + 32'(4 * i), 32'h22220000 + 32'(i), 0, "t2fill");
        end
        chk("t2_count_full", count, 4);
        anyReq = 1'b0;
        repeat (5) begin
            tick();
            if (ireq.valid !== 1'b0) anyReq = 1'b1;
        end
        chk("t2_no_5th_req", anyReq, 0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        fetchOne(32'hbfc00010, 32'h22220004, 0, "t2refill");
        chk("t2_count_refull", count, 4);
        anyReq = 1'b0;
        repeat (3) begin
            tick();
            if (ireq.valid !== 1'b0) anyReq = 1'b1;
        end
        chk("t2_no_req_after_refill", anyReq, 0);
        out_ready = 1'b1;
        repeat (8) tick();
        chk("t2_drained", sbq.size(), 0);

        // Redirect during WAIT flushes queue and drops the stale response
        doReset();
        fetchOne(32'hbfc00000, 32'h33330000, 0, "t3a");
        chk("t3_count_pre", count, 1);
        waitReq(32'hbfc00004, "t3b");
        iresp.addr_ok = 1'b1;
        tick();
        iresp.addr_ok = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 32'h80001000;
        sbq.delete();
        tick();
        redirect_valid = 1'b0;
        chk("t3_count_flushed", count, 0);
        chk("t3_out_valid_flushed", out_valid, 0);
        chk("t3_no_req_in_kill", ireq.valid, 0);
        iresp.data_ok = 1'b1;
        iresp.data = 32'hdeadbeef;
        tick();
        iresp.data_ok = 1'b0;
        chk("t3_stale_dropped", count, 0);
        out_ready = 1'b1;
        fetchOne(32'h80001000, 32'h33331000, 0, "t3c");
        repeat (3) tick();
        chk("t3_drained", sbq.size(), 0);

        // Redirect during REQ with a slow addr_ok: address held, response dropped
        doReset();
        out_ready = 1'b1;
        waitReq(32'hbfc00000, "t4a");
        redirect_valid = 1'b1;
        redirect_pc = 32'h80002000;
        tick();
        redirect_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("t4_kill_req_valid", ireq.valid, 1);
            chk("t4_kill_req_addr", ireq.addr, 32'hbfc00000);
            if (i < 2) tick();
        end
        iresp.addr_ok = 1'b1;
        tick();
        iresp.addr_ok = 1'b0;
        chk("t4_kill_wait_noreq", ireq.valid, 0);
        iresp.data_ok = 1'b1;
        iresp.data = 32'hbadc0de0;
        tick();
        iresp.data_ok = 1'b0;
        chk("t4_stale_dropped", count, 0);
        fetchOne(32'h80002000, 32'h44442000, 0, "t4b");
        repeat (3) tick();
        chk("t4_drained", sbq.size(), 0);

        // Misaligned redirect target yields one error entry and parks fetch
        doReset();
        redirect_valid = 1'b1;
        redirect_pc = 32'h80000002;
        tick();
        redirect_valid = 1'b0;
        sbq.push_back({32'h80000002, 32'h0, 1'b1});
        tick();
        chk("t5_count_one", count, 1);
        chk("t5_addr_error", out_addr_error, 1);
        chk("t5_instr_zero", out_instr, 0);
        chk("t5_pc", out_pc, 32'h80000002);
        anyReq = 1'b0;
        repeat (6) begin
            tick();
            if (ireq.valid !== 1'b0) anyReq = 1'b1;
        end
        chk("t5_no_req", anyReq, 0);
        chk("t5_count_still_one", count, 1);
        out_ready = 1'b1;
        tick();
        chk("t5_count_popped", count, 0);
        repeat (3) tick();
        chk("t5_no_req_after_pop", ireq.valid, 0);
        redirect_valid = 1'b1;
        redirect_pc = 32'h80003000;
        tick();
        redirect_valid = 1'b0;
        fetchOne(32'h80003000, 32'h55553000, 0, "t5b");
        repeat (3) tick();
        chk("t5_drained", sbq.size(), 0);

        // Asynchronous reset in the middle of WAIT
        doReset();
        fetchOne(32'hbfc00000, 32'h66660000, 0, "t6a");
        waitReq(32'hbfc00004, "t6b");
        iresp.addr_ok = 1'b1;
        tick();
        iresp.addr_ok = 1'b0;
        chk("t6_pre_out_valid", out_valid, 1);
        #2;
        resetn = 1'b0;
        #1;
        chk("t6_async_out_valid", out_valid, 0);
        chk("t6_async_ireq_valid", ireq.valid, 0);
        chk("t6_async_count", count, 0);
        sbq.delete();
        tick();
        resetn = 1'b1;
        out_ready = 1'b1;
        fetchOne(32'hbfc00000, 32'h66661111, 0, "t6c");
        repeat (3) tick();
        chk("t6_drained", sbq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, queue entries; power of two, range 2..16.
REQ-002 Parameter RESET_PC, default 32'hbfc0_0000, first fetch address after reset.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 resetn  input  1  reset, asynchronous, active-low.
REQ-005 ireq  output  ibus_req_t  instruction bus request (valid, addr).
REQ-006 iresp  input  ibus_resp_t  instruction bus response (addr_ok, data_ok, data).
REQ-007 redirect_valid  input  1  flush queue and restart fetch (branch/jump/exception).
REQ-008 redirect_pc  input  32  new fetch address, sampled when redirect_valid=1.
REQ-009 out_valid  output  1  head entry valid.
REQ-010 out_ready  input  1  consumer (decode) accepts head.
REQ-011 out_pc / out_instr  output  32 / 32  head entry PC and instruction word.
REQ-012 out_addr_error  output  1  head PC misaligned (pc[1:0]!=0); out_instr=0.
REQ-013 count  output  $clog2(DEPTH+1)  current entries.

Function
REQ-014 FSM states: IDLE, REQ, WAIT, KILL_REQ, KILL_WAIT; at most one bus request outstanding.
REQ-015 IDLE->REQ when count + pops-pending leaves a free slot, fetch_pc aligned, no redirect.
REQ-016 IDLE, free slot, fetch_pc misaligned: enqueue {fetch_pc, 0, addr_error=1} without bus access; fetch stops until redirect.
REQ-017 REQ: ireq.valid=1, ireq.addr=fetch_pc, held stable until addr_ok; addr_ok -> WAIT, or if data_ok same cycle enqueue and -> IDLE.
REQ-018 WAIT: ireq.valid=0; data_ok -> enqueue {fetch_pc, iresp.data, 0}, fetch_pc += 4, -> IDLE.
REQ-019 Enqueue never targets a full queue: slot reserved at REQ entry (count + 1 outstanding <= DEPTH).
REQ-020 Pop on out_valid & out_ready; out_valid = (count != 0); head fields combinational from storage.
REQ-021 Push and pop same cycle: count unchanged, ordering preserved; legal at full.
REQ-022 Read/write pointers log2(DEPTH) bits, natural wrap-around.
REQ-023 redirect_valid: queue cleared (count=0, pointers equal) next cycle; pop that cycle discarded; fetch_pc <= redirect_pc.
REQ-024 Redirect in REQ without addr_ok -> KILL_REQ (address held until addr_ok); with addr_ok -> KILL_WAIT; with addr_ok & data_ok -> IDLE.
REQ-025 Redirect in WAIT without data_ok -> KILL_WAIT; with data_ok -> IDLE, data discarded.
REQ-026 KILL_REQ: addr_ok -> KILL_WAIT (or IDLE if data_ok too); KILL_WAIT: data_ok -> IDLE; returned data never enqueued.
REQ-027 Redirect in KILL_* states updates fetch_pc only; state unchanged.
REQ-028 Redirect has priority over same-cycle enqueue and pop.
REQ-029 First request issued no earlier than cycle after redirect/reset; zero-wait bus gives one instruction per cycle sustained is NOT required (max 1 per 2 cycles).

Reset
REQ-030 resetn low: state=IDLE, fetch_pc=RESET_PC, count=0, pointers=0, ireq.valid=0, out_valid=0, out_addr_error=0; effective immediately, independent of clk.
REQ-031 Reset mid-transaction abandons outstanding request; no kill tracking after reset.
REQ-032 Storage array contents need not be reset.

Structure
REQ-033 ibus_req_t, ibus_resp_t, fetch entry struct and state enum live in the shared common package.
REQ-034 One sub-module fq_ram (DEPTH x 65-bit, one write, one async read port) is natural; pointers/FSM in fetch_queue.

Verification
REQ-035 Reset, bus addr_ok/data_ok 1 cycle each, out_ready=1 -> pcs bfc00000, bfc00004, bfc00008 in order, instrs match bus data.
REQ-036 out_ready=0, DEPTH=4 -> count reaches 4, ireq.valid stays 0, no 5th request; one pop -> one new request.
REQ-037 Redirect to 80001000 while in WAIT -> stale data_ok data discarded, next out_pc=80001000, count=0 cycle after redirect.
REQ-038 Redirect while REQ, addr_ok delayed 3 cycles -> ireq.addr held constant until addr_ok, then stale response dropped, fetch from new pc.
REQ-039 redirect_pc=80000002 -> single entry out_addr_error=1, out_instr=0, ireq.valid never asserted until next redirect.
REQ-040 resetn pulsed low mid-WAIT without clk edge -> out_valid=0, ireq.valid=0 immediately; fetch restarts at bfc00000.
